// File: rtl/sma_in_poller_pkg.sv
// sma_in_poller_pkg: shared FSM states, CSR map and PIO constants for the SMA input poller.
package sma_in_poller_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, CAPTURE} state_t;
  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_PERIOD = 2'd1;
  localparam logic [1:0] CSR_STATUS = 2'd2;
  localparam logic [1:0] CSR_COUNT  = 2'd3;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_RISE  = 1;
  localparam int CTRL_FALL  = 2;
  localparam int CTRL_IRQ   = 3;
  localparam int ST_PENDING = 0;
  localparam int ST_LEVEL   = 1;
  localparam int ST_RAW     = 2;
  localparam int ST_BUSY    = 3;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam logic [1:0] PIO_IDLE_ADDR = 2'd1;
endpackage

// File: rtl/sma_in_debounce.sv
// sma_in_debounce: DEB_N-deep sample history with priming; emits one-strobe rise/fall pulses.
module sma_in_debounce #(
  parameter int DEB_N = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic raw,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic primed
);
  logic [DEB_N-1:0] hist_q, hist_d, hist_n;
  logic [3:0] cnt_q, cnt_d;
  logic level_q, level_d, primed_q, primed_d, all1, all0, done;
  always_comb begin
    hist_n   = DEB_N'({hist_q, raw});
    all1     = &hist_n;
    all0     = ~|hist_n;
    done     = cnt_q == 4'(DEB_N - 1);
    rise     = strobe & primed_q & all1 & ~level_q;
    fall     = strobe & primed_q & all0 & level_q;
    hist_d   = clr ? '0 : (strobe ? hist_n : hist_q);
    cnt_d    = clr ? '0 : ((strobe & ~primed_q) ? cnt_q + 1'b1 : cnt_q);
    primed_d = clr ? 1'b0 : (primed_q | (strobe & done));
    // Priming completion and steady state share one rule: adopt a unanimous history.
    level_d  = (~clr & strobe & (primed_q | done)) ? (all1 ? 1'b1 : (all0 ? 1'b0 : level_q)) : level_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q   <= '0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      primed_q <= primed_d;
    end
  end
  assign level  = level_q;
  assign primed = primed_q;
endmodule

// File: rtl/sma_in_poller.sv
// sma_in_poller: polls the SMA input PIO at a programmable interval, debounces,
// counts qualified edges and raises a level interrupt.
module sma_in_poller
  import sma_in_poller_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int CNT_W    = 16,
  parameter int DEB_N    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic        irq,
  output logic [1:0]  pio_address,
  input  logic        pio_readdata
);
  state_t state_q, state_d;
  logic [3:0] ctrl_q, ctrl_d, status;
  logic [PERIOD_W-1:0] period_q, period_d, timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_b;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0] pio_addr_q, pio_addr_d;
  logic pending_q, pending_d, raw_q, raw_d;
  logic wr_ctrl, wr_period, wr_status, wr_count, en, strobe, qual;
  logic level, rise, fall, unused_primed, unused_wd;
  assign unused_wd = ^csr_writedata;
  sma_in_debounce #(.DEB_N(DEB_N)) u_deb (
    .clk    (clk),
    .reset  (reset),
    .strobe (strobe),
    .raw    (pio_readdata),
    .clr    (state_q == IDLE),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .primed (unused_primed)
  );
  always_comb begin
    wr_ctrl   = csr_write && csr_address == CSR_CTRL;
    wr_period = csr_write && csr_address == CSR_PERIOD;
    wr_status = csr_write && csr_address == CSR_STATUS;
    wr_count  = csr_write && csr_address == CSR_COUNT;
    ctrl_d    = wr_ctrl ? csr_writedata[3:0] : ctrl_q;
    period_d  = wr_period ? csr_writedata[PERIOD_W-1:0] : period_q;
    // The FSM follows the incoming enable so start and abort both act on the write edge.
    en        = ctrl_d[CTRL_EN];
    state_d   = state_q;
    timer_d   = timer_q;
    case (state_q)
      IDLE, CAPTURE: begin
        state_d = (period_q == '0) ? ISSUE : WAIT;
        timer_d = period_q - 1'b1;
      end
      WAIT: begin
        state_d = (timer_q == '0) ? ISSUE : WAIT;
        timer_d = timer_q - 1'b1;
      end
      default: state_d = CAPTURE;
    endcase
    state_d    = en ? state_d : IDLE;
    strobe     = state_q == CAPTURE && en;
    raw_d      = strobe ? pio_readdata : raw_q;
    qual       = (rise & ctrl_q[CTRL_RISE]) | (fall & ctrl_q[CTRL_FALL]);
    pending_d  = qual | (pending_q & ~(wr_status & csr_writedata[ST_PENDING]));
    cnt_b      = wr_count ? '0 : cnt_q;
    cnt_d      = (qual && ~&cnt_b) ? cnt_b + 1'b1 : cnt_b;
    pio_addr_d = (state_d == ISSUE) ? PIO_DATA_ADDR : PIO_IDLE_ADDR;
    status     = {state_q != IDLE, raw_q, level, pending_q};
    rdata_d    = !csr_read ? '0 :
                 csr_address == CSR_CTRL   ? 32'(ctrl_q) :
                 csr_address == CSR_PERIOD ? 32'(period_q) :
                 csr_address == CSR_STATUS ? 32'(status) : 32'(cnt_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      period_q   <= '0;
      timer_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      pio_addr_q <= PIO_IDLE_ADDR;
      pending_q  <= 1'b0;
      raw_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      pio_addr_q <= pio_addr_d;
      pending_q  <= pending_d;
      raw_q      <= raw_d;
    end
  end
  assign csr_readdata = rdata_q;
  assign pio_address  = pio_addr_q;
  assign irq          = pending_q & ctrl_q[CTRL_IRQ];
endmodule
